// File: rtl/decode_pkg.sv
// Shared definitions for the operand-decode stage.
//   cls_e     - instruction class, in classification priority order
//   shmode_e  - barrel shifter operating mode
//   LSL..ROR  - shift-type encodings of insn[6:5]
//   CPSR_C    - bit position of the carry flag in the CPSR
//   classify  - maps an instruction word to its class
package decode_pkg;

  typedef enum logic [2:0] {
    CLS_MUL,
    CLS_DP,
    CLS_LS,
    CLS_BLK,
    CLS_BR,
    CLS_NONE
  } cls_e;

  typedef enum logic [1:0] {
    SH_IMM_ROT,
    SH_IMM_SHIFT,
    SH_REG_SHIFT
  } shmode_e;

  localparam logic [1:0] LSL = 2'd0;
  localparam logic [1:0] LSR = 2'd1;
  localparam logic [1:0] ASR = 2'd2;
  localparam logic [1:0] ROR = 2'd3;

  localparam int CPSR_C = 29;

  // Multiply shares the 00 major opcode with data processing, so it is
  // tested first.
  function automatic cls_e classify(input logic [31:0] insn);
    if (insn[27:22] == 6'd0 && insn[7:4] == 4'b1001) return CLS_MUL;
    if (insn[27:26] == 2'b00)                        return CLS_DP;
    if (insn[27:26] == 2'b01)                        return CLS_LS;
    if (insn[27:25] == 3'b100)                       return CLS_BLK;
    if (insn[27:25] == 3'b101)                       return CLS_BR;
    return CLS_NONE;
  endfunction

endpackage

// File: rtl/decode_shifter.sv
// Combinational ARM barrel shifter.
//   i_value  - operand to shift (imm8 zero-extended in rotate mode)
//   i_type   - LSL/LSR/ASR/ROR
//   i_amount - shift amount; only [4:0] matters outside register mode
//   i_mode   - immediate rotate, shift by immediate, shift by register
//   i_cin    - incoming C flag
//   o_result - shifted value
//   o_cout   - shifter carry-out
module decode_shifter
  import decode_pkg::*;
(
  input  logic [31:0] i_value,
  input  logic [1:0]  i_type,
  input  logic [7:0]  i_amount,
  input  shmode_e     i_mode,
  input  logic        i_cin,
  output logic [31:0] o_result,
  output logic        o_cout
);

  logic [4:0]         w_n5;
  logic [32:0]        w_lsl;
  logic [32:0]        w_lsr;
  logic signed [32:0] w_asr;
  logic [31:0]        w_ror;
  logic [31:0]        w_small_res;
  logic               w_small_c;

  assign w_n5 = i_amount[4:0];

  // Extra guard bit catches the last bit shifted out (valid for n = 1..31).
  assign w_lsl = {1'b0, i_value} << w_n5;
  assign w_lsr = {i_value, 1'b0} >> w_n5;
  assign w_asr = $signed({i_value, 1'b0}) >>> w_n5;
  assign w_ror = (i_value >> w_n5) | (i_value << (6'd32 - {1'b0, w_n5}));

  always_comb begin
    w_small_res = w_ror;
    w_small_c   = w_ror[31];
    case (i_type)
      LSL:     begin w_small_res = w_lsl[31:0]; w_small_c = w_lsl[32]; end
      LSR:     begin w_small_res = w_lsr[32:1]; w_small_c = w_lsr[0];  end
      ASR:     begin w_small_res = w_asr[32:1]; w_small_c = w_asr[0];  end
      default: ;
    endcase
  end

  always_comb begin
    o_result = i_value;
    o_cout   = i_cin;
    case (i_mode)
      SH_IMM_ROT: begin
        o_result = w_ror;
        o_cout   = (w_n5 == 5'd0) ? i_cin : w_ror[31];
      end
      SH_IMM_SHIFT: begin
        if (w_n5 != 5'd0) begin
          o_result = w_small_res;
          o_cout   = w_small_c;
        end else begin
          // A zero amount encodes LSR/ASR #32 and RRX.
          case (i_type)
            LSR:     begin o_result = '0;                o_cout = i_value[31]; end
            ASR:     begin o_result = {32{i_value[31]}}; o_cout = i_value[31]; end
            ROR:     begin o_result = {i_cin, i_value[31:1]}; o_cout = i_value[0]; end
            default: ;
          endcase
        end
      end
      SH_REG_SHIFT: begin
        if (i_amount == 8'd0) begin
          o_result = i_value;
          o_cout   = i_cin;
        end else if (i_type == ROR) begin
          // Multiples of 32 leave the value in place but still set carry.
          o_result = (w_n5 == 5'd0) ? i_value     : w_small_res;
          o_cout   = (w_n5 == 5'd0) ? i_value[31] : w_small_c;
        end else if (i_amount[7:5] == 3'd0) begin
          o_result = w_small_res;
          o_cout   = w_small_c;
        end else begin
          case (i_type)
            LSL:     begin o_result = '0; o_cout = (i_amount == 8'd32) & i_value[0];  end
            LSR:     begin o_result = '0; o_cout = (i_amount == 8'd32) & i_value[31]; end
            default: begin o_result = {32{i_value[31]}}; o_cout = i_value[31]; end
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode.sv
// Operand-decode stage: classifies the instruction, drives the three
// register-file read addresses, substitutes PC+8 for R15, runs the barrel
// shifter and registers three operands plus the shifter carry.
//   clk, Nrst            - clock, async active-low reset
//   insn, inpc, incpsr   - instruction, its address, current CPSR
//   read_0..2 / rdata_0..2 - combinational regfile read port pairs
//   op0..2, carry        - registered operands and carry for execute
module decode
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        Nrst,
  input  logic [31:0] insn,
  input  logic [31:0] inpc,
  input  logic [31:0] incpsr,
  output logic [3:0]  read_0,
  output logic [3:0]  read_1,
  output logic [3:0]  read_2,
  input  logic [31:0] rdata_0,
  input  logic [31:0] rdata_1,
  input  logic [31:0] rdata_2,
  output logic [31:0] op0,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic        carry
);

  cls_e        w_cls;
  logic [31:0] w_pc8;
  logic        w_c;
  logic [31:0] w_src0, w_src1, w_src2;
  shmode_e     w_sh_mode;
  logic [31:0] w_sh_val;
  logic [7:0]  w_sh_amt;
  logic [31:0] w_sh_res;
  logic        w_sh_cout;
  logic [31:0] w_op0, w_op1, w_op2;
  logic        w_carry;
  logic [31:0] r_op0, r_op1, r_op2;
  logic        r_carry;
  logic        w_unused;

  assign w_cls    = classify(insn);
  assign w_pc8    = inpc + 32'd8;
  assign w_c      = incpsr[CPSR_C];
  assign w_unused = ^{insn[31:28], incpsr[31:30], incpsr[28:0]};

  always_comb begin
    read_0 = 4'd0;
    read_1 = 4'd0;
    read_2 = 4'd0;
    case (w_cls)
      CLS_MUL: begin read_0 = insn[15:12]; read_1 = insn[3:0]; read_2 = insn[11:8];  end
      CLS_DP:  begin read_0 = insn[19:16]; read_1 = insn[3:0]; read_2 = insn[11:8];  end
      CLS_LS:  begin read_0 = insn[19:16]; read_1 = insn[3:0]; read_2 = insn[15:12]; end
      CLS_BLK: read_0 = insn[19:16];
      default: ;
    endcase
  end

  // R15 reads as the pipelined PC.
  assign w_src0 = (read_0 == 4'd15) ? w_pc8 : rdata_0;
  assign w_src1 = (read_1 == 4'd15) ? w_pc8 : rdata_1;
  assign w_src2 = (read_2 == 4'd15) ? w_pc8 : rdata_2;

  // Load/store register offsets only ever use shift-by-immediate.
  always_comb begin
    w_sh_mode = SH_IMM_SHIFT;
    if (w_cls == CLS_DP && insn[25])     w_sh_mode = SH_IMM_ROT;
    else if (w_cls == CLS_DP && insn[4]) w_sh_mode = SH_REG_SHIFT;
  end

  always_comb begin
    w_sh_val = w_src1;
    w_sh_amt = {3'd0, insn[11:7]};
    case (w_sh_mode)
      SH_IMM_ROT:   begin w_sh_val = {24'd0, insn[7:0]}; w_sh_amt = {3'd0, insn[11:8], 1'b0}; end
      SH_REG_SHIFT: w_sh_amt = w_src2[7:0];
      default: ;
    endcase
  end

  decode_shifter u_shifter (
    .i_value  (w_sh_val),
    .i_type   (insn[6:5]),
    .i_amount (w_sh_amt),
    .i_mode   (w_sh_mode),
    .i_cin    (w_c),
    .o_result (w_sh_res),
    .o_cout   (w_sh_cout)
  );

  always_comb begin
    w_op0   = '0;
    w_op1   = '0;
    w_op2   = '0;
    w_carry = w_c;
    case (w_cls)
      CLS_MUL: begin w_op0 = w_src0; w_op1 = w_src1; w_op2 = w_src2; end
      CLS_DP:  begin w_op0 = w_src0; w_op1 = w_sh_res; w_carry = w_sh_cout; end
      CLS_LS: begin
        w_op0 = w_src0;
        w_op1 = insn[25] ? w_sh_res : {20'd0, insn[11:0]};
        w_op2 = w_src2;
      end
      CLS_BLK: begin w_op0 = w_src0; w_op1 = {16'd0, insn[15:0]}; end
      CLS_BR:  begin w_op0 = w_pc8;  w_op1 = {{6{insn[23]}}, insn[23:0], 2'b00}; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      r_op0   <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_op0   <= w_op0;
      r_op1   <= w_op1;
      r_op2   <= w_op2;
      r_carry <= w_carry;
    end
  end

  assign op0   = r_op0;
  assign op1   = r_op1;
  assign op2   = r_op2;
  assign carry = r_carry;

endmodule

// File: tb/tb_decode.sv
// Randomized self-checking bench for decode, with directed corner cases.
module tb_decode;

  logic        clk = 1'b0;
  logic        Nrst;
  logic [31:0] insn, inpc, incpsr;
  logic [3:0]  read_0, read_1, read_2;
  logic [31:0] rdata_0, rdata_1, rdata_2;
  logic [31:0] op0, op1, op2;
  logic        carry;

  logic [31:0] rf [16];
  int          errs   = 0;
  int          checks = 0;

  assign rdata_0 = rf[read_0];
  assign rdata_1 = rf[read_1];
  assign rdata_2 = rf[read_2];

  always #5 clk = ~clk;

  decode dut (
    .clk(clk), .Nrst(Nrst), .insn(insn), .inpc(inpc), .incpsr(incpsr),
    .read_0(read_0), .read_1(read_1), .read_2(read_2),
    .rdata_0(rdata_0), .rdata_1(rdata_1), .rdata_2(rdata_2),
    .op0(op0), .op1(op1), .op2(op2), .carry(carry)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---- reference model -------------------------------------------------
  function automatic logic [31:0] src(input logic [3:0] r, input logic [31:0] pc);
    return (r == 4'd15) ? pc + 32'd8 : rf[r];
  endfunction

  // One bit position per step; carry is the last bit moved out. {carry, value}.
  function automatic logic [32:0] shift_n(input logic [1:0] t, input logic [31:0] v,
                                          input int n, input logic c);
    for (int k = 0; k < n; k++) begin
      case (t)
        2'd0:    begin c = v[31]; v = v << 1;              end
        2'd1:    begin c = v[0];  v = v >> 1;              end
        2'd2:    begin c = v[0];  v = {v[31], v[31:1]};    end
        default: begin c = v[0];  v = {v[0], v[31:1]};     end
      endcase
    end
    return {c, v};
  endfunction

  function automatic logic [32:0] imm_shift(input logic [1:0] t, input logic [4:0] n,
                                            input logic [31:0] v, input logic c);
    if (n != 5'd0) return shift_n(t, v, int'(n), c);
    case (t)
      2'd0:    return {c, v};
      2'd3:    return {v[0], c, v[31:1]};
      default: return shift_n(t, v, 32, c);
    endcase
  endfunction

  task automatic model(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] cp,
                       output logic [11:0] rd, output logic [31:0] e0, output logic [31:0] e1,
                       output logic [31:0] e2, output logic ec);
    logic        c;
    logic [32:0] s;
    logic [31:0] rs;
    c  = cp[29];
    rd = '0; e0 = '0; e1 = '0; e2 = '0; ec = c;
    if (i[27:22] == 6'd0 && i[7:4] == 4'b1001) begin
      rd = {i[15:12], i[3:0], i[11:8]};
      e0 = src(i[15:12], pc); e1 = src(i[3:0], pc); e2 = src(i[11:8], pc);
    end else if (i[27:26] == 2'b00) begin
      rd = {i[19:16], i[3:0], i[11:8]};
      e0 = src(i[19:16], pc);
      if (i[25])     s = shift_n(2'd3, {24'd0, i[7:0]}, 2 * int'(i[11:8]), c);
      else if (i[4]) begin
        rs = src(i[11:8], pc);
        s  = shift_n(i[6:5], src(i[3:0], pc), int'(rs[7:0]), c);
      end else       s = imm_shift(i[6:5], i[11:7], src(i[3:0], pc), c);
      e1 = s[31:0]; ec = s[32];
    end else if (i[27:26] == 2'b01) begin
      rd = {i[19:16], i[3:0], i[15:12]};
      e0 = src(i[19:16], pc);
      s  = imm_shift(i[6:5], i[11:7], src(i[3:0], pc), c);
      e1 = i[25] ? s[31:0] : {20'd0, i[11:0]};
      e2 = src(i[15:12], pc);
    end else if (i[27:25] == 3'b100) begin
      rd = {i[19:16], 8'd0};
      e0 = src(i[19:16], pc);
      e1 = {16'd0, i[15:0]};
    end else if (i[27:25] == 3'b101) begin
      e0 = pc + 32'd8;
      e1 = {{6{i[23]}}, i[23:0], 2'b00};
    end
  endtask

  // Drive one instruction at posedge+1, check reads, then the captured operands.
  task automatic run(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] cp);
    logic [11:0] er;
    logic [31:0] e0, e1, e2;
    logic        ec;
    insn = i; inpc = pc; incpsr = cp;
    model(i, pc, cp, er, e0, e1, e2, ec);
    #1;
    chk("reads", {20'd0, read_0, read_1, read_2}, {20'd0, er});
    @(posedge clk); #1;
    chk("op0",   op0, e0);
    chk("op1",   op1, e1);
    chk("op2",   op2, e2);
    chk("carry", {31'd0, carry}, {31'd0, ec});
  endtask

  initial begin
    logic [31:0] r;
    Nrst = 1'b0; insn = 32'hE3A004FF; inpc = 32'h0; incpsr = 32'hFFFFFFFF;
    for (int k = 0; k < 16; k++) rf[k] = $urandom;
    #1;
    chk("rst_op0", op0, 32'd0);
    chk("rst_op1", op1, 32'd0);
    chk("rst_op2", op2, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);
    @(negedge clk); Nrst = 1'b1;
    @(posedge clk); #1;

    run(32'hE3A004FF, 32'h100, 32'h0);
    chk("immrot_op1", op1, 32'hFF000000);
    chk("immrot_c", {31'd0, carry}, 32'd1);

    rf[1] = 32'h80000001;
    run(32'hE1A00021, 32'h100, 32'h0);
    chk("lsr32_rd1", {28'd0, read_1}, 32'd1);
    chk("lsr32_op1", op1, 32'd0);
    chk("lsr32_c", {31'd0, carry}, 32'd1);

    rf[1] = 32'h00000003;
    run(32'hE1A00061, 32'h100, 32'h20000000);
    chk("rrx_op1", op1, 32'h80000001);
    chk("rrx_c", {31'd0, carry}, 32'd1);
    run(32'hE1A00001, 32'h100, 32'h20000000);
    chk("lsl0_op1", op1, 32'h00000003);
    chk("lsl0_c", {31'd0, carry}, 32'd1);

    rf[2] = 32'h00000021;
    run(32'hE1A00211, 32'h100, 32'h20000000);
    chk("lslreg33_op1", op1, 32'd0);
    chk("lslreg33_c", {31'd0, carry}, 32'd0);

    run(32'hE08F0001, 32'h1000, 32'h0);
    chk("pc_op0", op0, 32'h00001008);

    run(32'hEAFFFFFE, 32'h2000, 32'h0);
    chk("br_op0", op0, 32'h00002008);
    chk("br_op1", op1, 32'hFFFFFFF8);

    rf[1] = 32'h00004000; rf[2] = 32'hCAFEF00D;
    run(32'hE5812004, 32'h100, 32'h0);
    chk("str_rd2", {28'd0, read_2}, 32'd2);
    chk("str_op1", op1, 32'd4);
    chk("str_op2", op2, 32'hCAFEF00D);

    // Mid-cycle reset must clear the operands without a clock edge.
    #2; Nrst = 1'b0; #1;
    chk("arst_op0", op0, 32'd0);
    chk("arst_op1", op1, 32'd0);
    chk("arst_op2", op2, 32'd0);
    chk("arst_carry", {31'd0, carry}, 32'd0);
    @(negedge clk); Nrst = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 400; n++) begin
      // Small register values exercise the register-shift boundaries.
      for (int k = 0; k < 2; k++)
        rf[$urandom_range(0, 15)] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40);
      r = $urandom;
      case ($urandom_range(0, 5))
        0: begin r[27:22] = 6'd0; r[7:4] = 4'b1001; end
        1: begin r[27:26] = 2'b00; if (!r[25] && r[4]) r[7] = 1'b0; end
        2: r[27:26] = 2'b01;
        3: r[27:25] = 3'b100;
        4: r[27:25] = 3'b101;
        default: r[27:26] = 2'b11;
      endcase
      run(r, $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- Operand-decode stage of the ARM-subset pipeline; sits after fetch, in parallel with issue.
- Classifies the 32-bit instruction and drives the three register-file read addresses.
- Substitutes PC+8 for R15, runs the barrel shifter, and registers three 32-bit operands plus the shifter carry for execute.

Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- Nrst  in  1  reset, asynchronous, active-low
- insn  in  32  instruction word from fetch
- inpc  in  32  address of insn
- incpsr  in  32  current CPSR; C flag is incpsr[29]
- read_0  out  4  regfile read address 0 (combinational)
- read_1  out  4  regfile read address 1 (combinational)
- read_2  out  4  regfile read address 2 (combinational)
- rdata_0  in  32  data for read_0, valid in the same cycle
- rdata_1  in  32  data for read_1, valid in the same cycle
- rdata_2  in  32  data for read_2, valid in the same cycle
- op0  out  32  registered operand 0
- op1  out  32  registered operand 1
- op2  out  32  registered operand 2
- carry  out  1  registered shifter carry-out

Behaviour:
- Reset: Nrst low clears op0, op1, op2 and carry to 0 asynchronously.
- Latency: read_* are combinational from insn. op*/carry update on every rising clk edge from the current insn; latency is 1 cycle.
- No stall input; the block captures every cycle.
- R15 rule: any operand sourced from register 15 uses inpc+8 (mod 2^32) instead of rdata.
- C denotes incpsr[29].

Instruction classes, checked in this order:
- Multiply: insn[27:22]=0, insn[7:4]=1001.
  - read_0=insn[15:12], read_1=insn[3:0], read_2=insn[11:8].
  - op0=Rn, op1=Rm, op2=Rs, carry=C.
- Data processing: insn[27:26]=00.
  - read_0=insn[19:16], read_1=insn[3:0], read_2=insn[11:8].
  - op0=Rn, op1=shifter result, op2=0, carry=shifter carry.
- Load/store single: insn[27:26]=01.
  - read_0=insn[19:16], read_1=insn[3:0], read_2=insn[15:12].
  - op0=Rn.
  - op1 = zero-extended imm12 when insn[25]=0; otherwise Rm shifted by immediate.
  - op2=Rd (store data), carry=C.
- Block transfer: insn[27:25]=100.
  - op0=Rn (insn[19:16]), op1={16'b0, insn[15:0]}, op2=0, carry=C.
- Branch: insn[27:25]=101.
  - op0=inpc+8, op1=sign-extend(insn[23:0])<<2, op2=0, carry=C.
- Any other: op0=op1=op2=0, carry=C.
- In all classes, read ports not listed drive 0.

Shifter, data-processing path:
- Immediate (insn[25]=1): value = imm8 rotated right by 2*insn[11:8].
  - carry = C when the rotate amount is 0, else value[31].
- Register shift by immediate (insn[4]=0): type insn[6:5], amount n=insn[11:7].
  - LSL: n=0 gives Rm with carry C; otherwise carry = Rm[32-n].
  - LSR: n=0 means 32, giving result 0 with carry Rm[31]; otherwise carry = Rm[n-1].
  - ASR: n=0 means 32, giving all bits = Rm[31] with carry Rm[31].
  - ROR: n=0 is RRX, giving {C, Rm[31:1]} with carry Rm[0].
- Register shift by register (insn[4]=1, insn[7]=0): n = Rs[7:0].
  - n=0: result Rm, carry C, for every type.
  - LSL: n=32 gives 0 with carry Rm[0]; n>32 gives 0 with carry 0.
  - LSR: n=32 gives 0 with carry Rm[31]; n>32 gives 0 with carry 0.
  - ASR: n≥32 gives sign-fill with carry Rm[31].
  - ROR: n[4:0]=0 (n nonzero) gives Rm with carry Rm[31]; otherwise rotate by n[4:0].

Decomposition:
- Shared package decode_pkg holds:
  - instruction-class enum
  - shift-type constants LSL=0, LSR=1, ASR=2, ROR=3
  - CPSR_C=29
- One sub-module, decode_shifter: purely combinational.
  - Inputs: value, type, amount[7:0], mode (imm-rotate / imm-shift / reg-shift), cin.
  - Outputs: result, cout.

Test Plan:
- Reset: Nrst=0 with any insn → op0..op2=0, carry=0, immediately, without waiting for a clock edge.
- Immediate rotate: insn=E3A004FF (MOV r0,#0xFF000000), C=0 → after 1 clk op1=FF000000, carry=1.
- Register LSR#32: insn=E1A00021 (LSR #0 encoding), rdata_1=80000001 → read_1=1, op1=0, carry=1.
- RRX: insn=E1A00061 with C=1 and rdata_1=00000003 → op1=80000001, carry=1. Repeat with insn=E1A00001 (LSL #0) and C=1 → op1 = rdata_1, carry=1 (carry passthrough).
- Reg shift ≥32 and PC substitution:
  - insn=E1A00211, rdata_2=00000021 (LSL by r2=33) → op1=0, carry=0.
  - insn=E08F0001 (ADD r0,pc,r1), inpc=1000 → op0=00001008.
- Branch and store:
  - insn=EAFFFFFE, inpc=2000 → op0=00002008, op1=FFFFFFF8.
  - insn=E5812004 (STR r2,[r1,#4]) → read_2=2, op1=4, op2=rdata_2.
